serial_frame_rx: RTL and testbench

//  Receiver for the single-wire serial frames driven onto the d line by the
//  bit-level stimulus and transmit logic. Detects a start bit, samples WIDTH

---
 rtl/serial_frame_rx.sv | 159 +++++++++++++++
 tb/tb_serial_frame_rx.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_rx.sv
// Single-wire serial frame receiver: start bit, WIDTH data bits LSB-first,
// optional even parity, stop bit; mid-bit sampling and a one-cycle result strobe.
module serial_frame_rx #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned PARITY_EN    = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             d,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    output logic             parity_err,
    output logic             frame_err,
    output logic             busy
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2);
    localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(WIDTH - 1);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StStart  = 3'd1;
    localparam logic [2:0] StData   = 3'd2;
    localparam logic [2:0] StParity = 3'd3;
    localparam logic [2:0] StStop   = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             par_q, par_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             perr_q, perr_d;
    logic             ferr_q, ferr_d;

    logic [WIDTH-1:0] shift_in;
    logic             mid_bit;
    logic             last_clk;

    // New bits enter at the MSB so that after WIDTH shifts the first bit sits at bit 0.
    if (WIDTH > 1) begin : g_shift_wide
        assign shift_in = {d, shift_q[WIDTH-1:1]};
    end else begin : g_shift_one
        assign shift_in = d;
    end

    assign mid_bit  = (cnt_q == CntHalf);
    assign last_clk = (cnt_q == CntLast);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        data_d  = data_q;
        valid_d = 1'b0;
        perr_d  = 1'b0;
        ferr_d  = 1'b0;

        if (state_q != StIdle) begin
            cnt_d = last_clk ? '0 : cnt_q + CntW'(1);
        end

        case (state_q)
            StIdle: begin
                // The detect edge itself counts as cnt=0 of the start bit.
                if (!d) begin
                    state_d = StStart;
                    cnt_d   = CntW'(1);
                    idx_d   = '0;
                end
            end
            StStart: begin
                if (mid_bit && d) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (last_clk) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (mid_bit) begin
                    shift_d = shift_in;
                end
                if (last_clk) begin
                    if (idx_q == IdxLast) begin
                        idx_d   = '0;
                        state_d = (PARITY_EN != 0) ? StParity : StStop;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
            end
            StParity: begin
                if (mid_bit) begin
                    par_d = d;
                end
                if (last_clk) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                // Leave at the sample point so a start bit right after the stop is caught.
                if (mid_bit) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    if (d) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        perr_d  = (PARITY_EN != 0) && (par_q != (^shift_q));
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end
    end

    assign data_out   = data_q;
    assign valid      = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: directed frames plus random frames, checked against
// a frame-level model of expected result strobes, their cycle and payload.
module tb_serial_frame_rx;

    localparam int unsigned W = 8;
    localparam int unsigned C = 4;
    localparam int unsigned P = 1;
    // Edges from start detect to the edge where the result strobe is seen high.
    localparam int LAT = (W + 1 + P) * C + C / 2 + 1;

    logic         clk;
    logic         reset;
    logic         d;
    logic [W-1:0] data_out;
    logic         valid;
    logic         parity_err;
    logic         frame_err;
    logic         busy;

    serial_frame_rx #(
        .WIDTH        (W),
        .CLKS_PER_BIT (C),
        .PARITY_EN    (P)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .d          (d),
        .data_out   (data_out),
        .valid      (valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit           good;
        logic [W-1:0] data;
        bit           perr;
        int           t;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] mdl_data;
    int           cyc;
    int           n_checks;
    int           n_errors;

    initial begin
        cyc      = 0;
        n_checks = 0;
        n_errors = 0;
        mdl_data = '0;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Result strobes are matched against the model queue in order of arrival.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset && (valid || frame_err || parity_err)) begin
            check_val("valid_ferr_exclusive", {31'd0, valid & frame_err}, 32'd0);
            check_val("perr_without_valid", {31'd0, parity_err & ~valid}, 32'd0);
            if (exp_q.size() == 0) begin
                check_val("unexpected_strobe", {30'd0, valid, frame_err}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_val("strobe_cycle", cyc + 1, e.t);
                check_val("strobe_valid", {31'd0, valid}, {31'd0, e.good});
                check_val("strobe_ferr", {31'd0, frame_err}, {31'd0, !e.good});
                if (e.good) begin
                    mdl_data = e.data;
                    check_val("parity_err", {31'd0, parity_err}, {31'd0, e.perr});
                end
                check_val("data_out", data_out, mdl_data);
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        d = b;
        wait_clk(C);
    endtask

    task automatic send_frame(input logic [W-1:0] data, input logic pbit, input logic stop);
        exp_t e;
        e.t    = cyc + 1 + LAT;
        e.good = stop;
        e.data = data;
        e.perr = (P != 0) && (pbit != (^data));
        exp_q.push_back(e);
        send_bit(1'b0);
        for (int i = 0; i < int'(W); i++) send_bit(data[i]);
        if (P != 0) send_bit(pbit);
        send_bit(stop);
        d = 1'b1;
    endtask

    task automatic drain(input string tag);
        d = 1'b1;
        wait_clk(6);
        check_val(tag, exp_q.size(), 32'd0);
        check_val({tag, "_data"}, data_out, mdl_data);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_data"}, data_out, 32'd0);
        check_val({tag, "_valid"}, {31'd0, valid}, 32'd0);
        check_val({tag, "_perr"}, {31'd0, parity_err}, 32'd0);
        check_val({tag, "_ferr"}, {31'd0, frame_err}, 32'd0);
        check_val({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin : stim
        int          nb;
        logic [W-1:0] rd;
        logic        wrong;
        logic        stop;
        reset = 1'b1;
        d     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        wait_clk(20);
        check_idle_outputs("reset");

        send_frame(8'hA5, 1'b0, 1'b1);
        drain("a5_pending");

        send_frame(8'h01, 1'b0, 1'b1);
        drain("01_pending");

        // One-clock low pulse: false start, busy for two cycles only.
        d = 1'b0;
        wait_clk(1);
        d  = 1'b1;
        nb = 0;
        repeat (6) begin
            @(negedge clk);
            nb += int'(busy);
        end
        wait_clk(1);
        check_val("glitch_busy_cycles", nb, 32'd2);
        drain("glitch_pending");

        send_frame(8'h3C, ^8'h3C, 1'b0);
        wait_clk(4);
        drain("ferr_pending");

        // Partial frame, then reset while in the data bits.
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        wait_clk(2);
        @(negedge clk);
        check_val("busy_mid_data", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        d     = 1'b1;
        wait_clk(1);
        reset = 1'b0;
        @(negedge clk);
        check_idle_outputs("mid_reset");
        mdl_data = '0;
        exp_q.delete();
        wait_clk(4);

        send_frame(8'h5A, ^8'h5A, 1'b1);
        send_frame(8'hFF, ^8'hFF, 1'b1);
        drain("b2b_pending");

        for (int k = 0; k < 40; k++) begin
            rd    = W'($urandom);
            wrong = ($urandom_range(3) == 0);
            stop  = ($urandom_range(7) != 0);
            if ($urandom_range(5) == 0) begin
                d = 1'b0;
                wait_clk(1);
                d = 1'b1;
                wait_clk(4);
            end
            send_frame(rd, (^rd) ^ wrong, stop);
            d = 1'b1;
            wait_clk(stop ? int'($urandom_range(3)) : int'($urandom_range(6, 3)));
        end
        drain("random_pending");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
